// File: rtl/int_issue_queue_pkg.sv
// Shared types for the integer issue queue: dispatch entry layout and
// CDB widths. The int_fifo_data layout is 101 bits and matches the
// dispatch FIFO that feeds this block.
package int_issue_queue_pkg;

  localparam int CDB_TAG_W = 6;
  localparam int DATA_W    = 32;

  // Operand payload shared by all dispatch FIFOs.
  typedef struct packed {
    logic [DATA_W-1:0]    rs1_data;
    logic [DATA_W-1:0]    rs2_data;
    logic [CDB_TAG_W-1:0] rs1_tag;
    logic [CDB_TAG_W-1:0] rs2_tag;
    logic                 rs1_data_valid;
    logic                 rs2_data_valid;
    logic [CDB_TAG_W-1:0] rd_tag;
  } common_fifo_data;

  // Integer dispatch entry: decoded opcode fields plus operand payload.
  typedef struct packed {
    logic [6:0]      opcode;
    logic [2:0]      func3;
    logic [6:0]      func7;
    common_fifo_data common_data;
  } int_fifo_data;

  // True when a broadcast on the CDB resolves an operand still pending.
  function automatic logic cdb_hit(input logic                 cdb_valid,
                                   input logic [CDB_TAG_W-1:0] cdb_tag,
                                   input logic                 op_valid,
                                   input logic [CDB_TAG_W-1:0] op_tag);
    return cdb_valid && !op_valid && (op_tag == cdb_tag);
  endfunction

endpackage

// File: rtl/int_issue_queue_sel.sv
// iq_oldest_ready_sel: combinational priority encoder. Returns the lowest
// index whose ready bit is set; index 0 is the oldest queue slot.
module iq_oldest_ready_sel #(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] ready,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  // Scan from the youngest slot down so the oldest ready slot wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_issue_queue.sv
// int_issue_queue: age-ordered integer issue queue. Holds dispatched
// entries, wakes pending operands from the CDB and issues the oldest
// ready entry over a valid/ready handshake. Slot 0 is always the oldest;
// issuing compacts the younger slots down by one.
// Optional feature macro: INT_IQ_WAKEUP_BYPASS_EN lets an entry issue in
// the same cycle as the CDB broadcast that completes its operands.
module int_issue_queue
  import int_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 int_dispatch_en,
  input  int_fifo_data         i_int_fifo_data,
  input  logic                 flush,
  input  logic                 cdb_valid,
  input  logic [CDB_TAG_W-1:0] cdb_tag,
  input  logic [DATA_W-1:0]    cdb_data,
  input  logic                 issue_ready,
  output logic                 issue_valid,
  output int_fifo_data         o_issue_data,
  output logic                 queue_full,
  output logic [CNT_W-1:0]     queue_count,
  output logic                 dispatch_drop
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  int_fifo_data     entry_reg  [DEPTH];
  int_fifo_data     entry_next [DEPTH];
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             drop_reg;
  logic             drop_next;

  logic [DEPTH-1:0] slot_ready;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             issue_fire;
  logic             dispatch_fire;
  logic [CNT_W-1:0] wr_slot;

  // Per-slot readiness: stored valid bits, optionally widened by a
  // same-cycle CDB match on a still-pending operand.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ready
      logic rs1_ok;
      logic rs2_ok;
`ifdef INT_IQ_WAKEUP_BYPASS_EN
      assign rs1_ok = entry_reg[gi].common_data.rs1_data_valid ||
                      cdb_hit(cdb_valid, cdb_tag,
                              entry_reg[gi].common_data.rs1_data_valid,
                              entry_reg[gi].common_data.rs1_tag);
      assign rs2_ok = entry_reg[gi].common_data.rs2_data_valid ||
                      cdb_hit(cdb_valid, cdb_tag,
                              entry_reg[gi].common_data.rs2_data_valid,
                              entry_reg[gi].common_data.rs2_tag);
`else
      assign rs1_ok = entry_reg[gi].common_data.rs1_data_valid;
      assign rs2_ok = entry_reg[gi].common_data.rs2_data_valid;
`endif
      assign slot_ready[gi] = valid_reg[gi] && rs1_ok && rs2_ok;
    end
  endgenerate

  iq_oldest_ready_sel #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_sel (
    .ready (slot_ready),
    .found (sel_found),
    .idx   (sel_idx)
  );

  assign issue_valid   = sel_found;
  assign queue_full    = (count_reg == CNT_W'(DEPTH));
  assign queue_count   = count_reg;
  assign dispatch_drop = drop_reg;

  // Present the selected entry, with bypassed CDB data spliced in when
  // the broadcast resolves it this cycle; zeros when nothing is ready.
  always_comb begin
    o_issue_data = '0;
    if (sel_found) begin
      o_issue_data = entry_reg[sel_idx];
`ifdef INT_IQ_WAKEUP_BYPASS_EN
      if (cdb_hit(cdb_valid, cdb_tag,
                  entry_reg[sel_idx].common_data.rs1_data_valid,
                  entry_reg[sel_idx].common_data.rs1_tag)) begin
        o_issue_data.common_data.rs1_data       = cdb_data;
        o_issue_data.common_data.rs1_data_valid = 1'b1;
      end
      if (cdb_hit(cdb_valid, cdb_tag,
                  entry_reg[sel_idx].common_data.rs2_data_valid,
                  entry_reg[sel_idx].common_data.rs2_tag)) begin
        o_issue_data.common_data.rs2_data       = cdb_data;
        o_issue_data.common_data.rs2_data_valid = 1'b1;
      end
`endif
    end
  end

  // Next queue state: compact after issue, append dispatch at the
  // post-issue tail, then apply CDB wakeup; flush clears everything.
  always_comb begin
    issue_fire    = sel_found && issue_ready;
    dispatch_fire = int_dispatch_en && !queue_full && !flush;
    wr_slot       = count_reg - CNT_W'(issue_fire);

    for (int i = 0; i < DEPTH; i++) begin
      entry_next[i] = entry_reg[i];
      valid_next[i] = valid_reg[i];
    end

    if (issue_fire) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx) begin
          entry_next[i] = entry_reg[i+1];
          valid_next[i] = valid_reg[i+1];
        end
      end
      valid_next[DEPTH-1] = 1'b0;
    end

    if (dispatch_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_slot == CNT_W'(i)) begin
          entry_next[i] = i_int_fifo_data;
          valid_next[i] = 1'b1;
        end
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (valid_next[i]) begin
        if (cdb_hit(cdb_valid, cdb_tag,
                    entry_next[i].common_data.rs1_data_valid,
                    entry_next[i].common_data.rs1_tag)) begin
          entry_next[i].common_data.rs1_data       = cdb_data;
          entry_next[i].common_data.rs1_data_valid = 1'b1;
        end
        if (cdb_hit(cdb_valid, cdb_tag,
                    entry_next[i].common_data.rs2_data_valid,
                    entry_next[i].common_data.rs2_tag)) begin
          entry_next[i].common_data.rs2_data       = cdb_data;
          entry_next[i].common_data.rs2_data_valid = 1'b1;
        end
      end
    end

    count_next = count_reg + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
    drop_next  = drop_reg || (int_dispatch_en && queue_full);

    if (flush) begin
      valid_next = '0;
      count_next = '0;
    end
  end

  // Control state: valid bits, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= '0;
      count_reg <= '0;
      drop_reg  <= 1'b0;
    end else begin
      valid_reg <= valid_next;
      count_reg <= count_next;
      drop_reg  <= drop_next;
    end
  end

  // Entry payload; only meaningful where the matching valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_reg[i] <= entry_next[i];
    end
  end

endmodule

// File: tb/tb_int_issue_queue.sv
// Testbench for int_issue_queue: directed scenarios followed by random
// traffic, checked each cycle against a queue-based reference model.
// Honours INT_IQ_WAKEUP_BYPASS_EN when the design is built with it.
module tb_int_issue_queue;
  import int_issue_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 int_dispatch_en;
  int_fifo_data         i_int_fifo_data;
  logic                 flush;
  logic                 cdb_valid;
  logic [CDB_TAG_W-1:0] cdb_tag;
  logic [DATA_W-1:0]    cdb_data;
  logic                 issue_ready;
  logic                 issue_valid;
  int_fifo_data         o_issue_data;
  logic                 queue_full;
  logic [CNT_W-1:0]     queue_count;
  logic                 dispatch_drop;

  int tests = 0;
  int fails = 0;

  int_fifo_data mq[$];
  bit           m_drop = 1'b0;

  always #5 clk = ~clk;

  int_issue_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .int_dispatch_en (int_dispatch_en),
    .i_int_fifo_data (i_int_fifo_data),
    .flush           (flush),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .cdb_data        (cdb_data),
    .issue_ready     (issue_ready),
    .issue_valid     (issue_valid),
    .o_issue_data    (o_issue_data),
    .queue_full      (queue_full),
    .queue_count     (queue_count),
    .dispatch_drop   (dispatch_drop)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int_fifo_data mk(input logic [6:0] op, input logic [31:0] d1, input logic v1,
                                      input logic [5:0] t1, input logic [31:0] d2, input logic v2,
                                      input logic [5:0] t2, input logic [5:0] rd);
    int_fifo_data e;
    e = '0;
    e.opcode = op;
    e.func3 = op[2:0];
    e.func7 = {op[3:0], 3'b101};
    e.common_data.rs1_data = d1;
    e.common_data.rs1_data_valid = v1;
    e.common_data.rs1_tag = t1;
    e.common_data.rs2_data = d2;
    e.common_data.rs2_data_valid = v2;
    e.common_data.rs2_tag = t2;
    e.common_data.rd_tag = rd;
    return e;
  endfunction

  // Operand counts as available for selection this cycle.
  function automatic bit op_avail(input logic v, input logic [5:0] t);
`ifdef INT_IQ_WAKEUP_BYPASS_EN
    return v || (cdb_valid && t == cdb_tag);
`else
    return v;
`endif
  endfunction

  // Entry as the execution unit should see it this cycle.
  function automatic int_fifo_data resolved(input int_fifo_data e);
    int_fifo_data r;
    r = e;
`ifdef INT_IQ_WAKEUP_BYPASS_EN
    if (cdb_valid && !e.common_data.rs1_data_valid && e.common_data.rs1_tag == cdb_tag) begin
      r.common_data.rs1_data = cdb_data;
      r.common_data.rs1_data_valid = 1'b1;
    end
    if (cdb_valid && !e.common_data.rs2_data_valid && e.common_data.rs2_tag == cdb_tag) begin
      r.common_data.rs2_data = cdb_data;
      r.common_data.rs2_data_valid = 1'b1;
    end
`endif
    return r;
  endfunction

  // One clock: compare outputs with the model mid-cycle, then advance the
  // model with the inputs applied during this cycle.
  task automatic cycle();
    int k;
    bit full_pre;
    int_fifo_data exp_data;
    @(negedge clk);
    k = -1;
    foreach (mq[i]) begin
      if (k < 0 && op_avail(mq[i].common_data.rs1_data_valid, mq[i].common_data.rs1_tag)
                && op_avail(mq[i].common_data.rs2_data_valid, mq[i].common_data.rs2_tag))
        k = i;
    end
    exp_data = (k >= 0) ? resolved(mq[k]) : '0;
    chk("issue_valid", issue_valid, (k >= 0));
    chk("issue_data", o_issue_data, exp_data);
    chk("queue_count", queue_count, mq.size());
    chk("queue_full", queue_full, (mq.size() == DEPTH));
    chk("dispatch_drop", dispatch_drop, m_drop);
    if (k >= 0 && issue_ready)
      $display("[TB] t=%0t issue rd_tag=%0d rs1=%0h rs2=%0h", $time,
               exp_data.common_data.rd_tag, exp_data.common_data.rs1_data,
               exp_data.common_data.rs2_data);
    full_pre = (mq.size() == DEPTH);
    if (int_dispatch_en && full_pre) m_drop = 1'b1;
    if (flush) begin
      mq.delete();
    end else begin
      if (k >= 0 && issue_ready) mq.delete(k);
      if (int_dispatch_en && !full_pre) mq.push_back(i_int_fifo_data);
      if (cdb_valid) begin
        foreach (mq[i]) begin
          if (!mq[i].common_data.rs1_data_valid && mq[i].common_data.rs1_tag == cdb_tag) begin
            mq[i].common_data.rs1_data = cdb_data;
            mq[i].common_data.rs1_data_valid = 1'b1;
          end
          if (!mq[i].common_data.rs2_data_valid && mq[i].common_data.rs2_tag == cdb_tag) begin
            mq[i].common_data.rs2_data = cdb_data;
            mq[i].common_data.rs2_data_valid = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    int_dispatch_en = 1'b0;
    i_int_fifo_data = '0;
    flush = 1'b0;
    cdb_valid = 1'b0;
    cdb_tag = '0;
    cdb_data = '0;
    issue_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    chk("rst_issue_valid", issue_valid, 1'b0);
    chk("rst_count", queue_count, 0);
    chk("rst_full", queue_full, 1'b0);
    chk("rst_drop", dispatch_drop, 1'b0);
    chk("rst_data", o_issue_data, '0);
    rst_n = 1'b1;

    // ADDI with both operands ready
    int_dispatch_en = 1'b1;
    i_int_fifo_data = mk(7'h13, 32'd5, 1'b1, 6'd1, 32'd0, 1'b1, 6'd2, 6'd10);
    issue_ready = 1'b1;
    cycle();
    int_dispatch_en = 1'b0;
    chk("addi_valid", issue_valid, 1'b1);
    chk("addi_rs1", o_issue_data.common_data.rs1_data, 32'd5);
    cycle();
    chk("addi_count_after", queue_count, 0);

    // Fill to full, then overflow
    issue_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      int_dispatch_en = 1'b1;
      i_int_fifo_data = mk(7'h33, 32'(i + 100), 1'b1, 6'd0, 32'(i + 200), 1'b1, 6'd0, 6'(i + 20));
      cycle();
    end
    chk("fill_full", queue_full, 1'b1);
    chk("fill_count", queue_count, 4);
    i_int_fifo_data = mk(7'h33, 32'd999, 1'b1, 6'd0, 32'd0, 1'b1, 6'd0, 6'd30);
    cycle();
    int_dispatch_en = 1'b0;
    chk("overflow_drop", dispatch_drop, 1'b1);
    chk("overflow_count", queue_count, 4);
    issue_ready = 1'b1;
    repeat (DEPTH) cycle();
    chk("drain_count", queue_count, 0);

    // Wakeup of rs2 from the CDB
    issue_ready = 1'b0;
    int_dispatch_en = 1'b1;
    i_int_fifo_data = mk(7'h33, 32'd7, 1'b1, 6'd0, 32'd0, 1'b0, 6'h12, 6'd11);
    cycle();
    int_dispatch_en = 1'b0;
    chk("wait_not_ready", issue_valid, 1'b0);
    cdb_valid = 1'b1;
    cdb_tag = 6'h12;
    cdb_data = 32'hDEADBEEF;
    issue_ready = 1'b1;
    cycle();
    cdb_valid = 1'b0;
`ifdef INT_IQ_WAKEUP_BYPASS_EN
    chk("bypass_issued", queue_count, 0);
`else
    chk("wake_valid", issue_valid, 1'b1);
    chk("wake_rs2", o_issue_data.common_data.rs2_data, 32'hDEADBEEF);
`endif
    cycle();
    chk("wake_done", queue_count, 0);

    // Older entry blocked, younger one issues first
    issue_ready = 1'b0;
    int_dispatch_en = 1'b1;
    i_int_fifo_data = mk(7'h13, 32'd0, 1'b0, 6'd3, 32'd1, 1'b1, 6'd0, 6'd40);
    cycle();
    i_int_fifo_data = mk(7'h33, 32'd2, 1'b1, 6'd0, 32'd3, 1'b1, 6'd0, 6'd41);
    cycle();
    int_dispatch_en = 1'b0;
    chk("ooo_sel_rd", o_issue_data.common_data.rd_tag, 6'd41);
    issue_ready = 1'b1;
    cycle();
    chk("ooo_left", queue_count, 1);
    chk("ooo_blocked", issue_valid, 1'b0);
    cdb_valid = 1'b1;
    cdb_tag = 6'd3;
    cdb_data = 32'h1234;
    cycle();
    cdb_valid = 1'b0;
    cycle();
    chk("ooo_done", queue_count, 0);

    // Capture during the dispatch cycle
    issue_ready = 1'b0;
    int_dispatch_en = 1'b1;
    i_int_fifo_data = mk(7'h13, 32'd0, 1'b0, 6'd9, 32'd4, 1'b1, 6'd0, 6'd42);
    cdb_valid = 1'b1;
    cdb_tag = 6'd9;
    cdb_data = 32'h55;
    cycle();
    int_dispatch_en = 1'b0;
    cdb_valid = 1'b0;
    chk("cap_valid", issue_valid, 1'b1);
    chk("cap_rs1", o_issue_data.common_data.rs1_data, 32'h55);
    issue_ready = 1'b1;
    cycle();

    // Flush with a simultaneous dispatch
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int_dispatch_en = 1'b1;
      i_int_fifo_data = mk(7'h33, 32'(i), 1'b1, 6'd0, 32'(i), 1'b1, 6'd0, 6'(i + 50));
      cycle();
    end
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    int_dispatch_en = 1'b0;
    chk("flush_count", queue_count, 0);
    chk("flush_full", queue_full, 1'b0);
    chk("flush_valid", issue_valid, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      int_dispatch_en = ($urandom_range(0, 99) < 50);
      i_int_fifo_data = mk(7'($urandom), $urandom, 1'($urandom_range(0, 99) < 40),
                           6'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 99) < 40),
                           6'($urandom_range(0, 7)), 6'($urandom));
      cdb_valid = ($urandom_range(0, 99) < 40);
      cdb_tag = 6'($urandom_range(0, 7));
      cdb_data = $urandom;
      issue_ready = ($urandom_range(0, 99) < 60);
      flush = ($urandom_range(0, 99) < 3);
      cycle();
    end
    idle_inputs();

    // Asynchronous reset in mid-operation
    int_dispatch_en = 1'b1;
    i_int_fifo_data = mk(7'h13, 32'd1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd60);
    cycle();
    int_dispatch_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    m_drop = 1'b0;
    chk("arst_count", queue_count, 0);
    chk("arst_valid", issue_valid, 1'b0);
    chk("arst_drop", dispatch_drop, 1'b0);
    #2;
    rst_n = 1'b1;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_issue_queue.md
Name: int_issue_queue

Overview:
- Receiving end of the integer dispatch path.
- Accepts int_fifo_data entries when int_dispatch_en is asserted, holds them in a DEPTH-entry age-ordered queue, and snoops the CDB to wake up pending source operands.
- Issues the oldest entry with both operands valid to the integer execution unit, using a valid/ready handshake.
- Reports full/count back to dispatch so dispatch can stall.

Parameters:
- DEPTH, 4, number of queue entries (power of two not required, minimum 2).
- CNT_W, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- int_dispatch_en  in  1  dispatch write request.
- i_int_fifo_data  in  int_fifo_data (101)  dispatched entry: opcode, func3, func7, common_data (rs1/rs2 data, rs1/rs2 tag, rs1/rs2 data_valid, rd_tag).
- flush  in  1  synchronous flush on branch mispredict.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  6  CDB producer tag.
- cdb_data  in  32  CDB result.
- issue_ready  in  1  integer unit can accept an entry this cycle.
- issue_valid  out  1  o_issue_data holds an issuable entry.
- o_issue_data  out  int_fifo_data (101)  selected entry, both operands resolved.
- queue_full  out  1  all DEPTH entries valid (registered-state derived).
- queue_count  out  CNT_W  number of valid entries.
- dispatch_drop  out  1  sticky: a dispatch arrived while full; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): all entry valid bits 0, dispatch_drop 0. This gives issue_valid=0, queue_full=0, queue_count=0 and o_issue_data all zeros. Reset mid-operation discards all entries immediately.
- Storage: entry[0] is the oldest. Each entry holds the full struct plus a valid bit.
- Select:
  - Issue candidate = lowest index i with valid && rs1_data_valid && rs2_data_valid.
  - issue_valid is combinational from registered entry state.
  - o_issue_data = entry[i], or zeros when none.
- Issue: fires when issue_valid && issue_ready. At the clock edge, entry[i] is removed and entries i+1..DEPTH-1 shift down one slot. Order among the remaining entries is preserved.
- Dispatch:
  - Fires when int_dispatch_en && !queue_full && !flush.
  - The new entry is written into the slot equal to the post-issue occupancy, i.e. index count-1 if an issue fires this cycle, else index count.
  - Dispatch and issue in the same cycle are both honoured, and the count is unchanged.
  - queue_full is based on current state, so dispatch while full is refused even if an issue fires that cycle.
  - A refused dispatch (while full) sets dispatch_drop and the entry is discarded.
- Wakeup:
  - Every cycle with cdb_valid, each valid entry with rsX_data_valid=0 and rsX_tag==cdb_tag captures cdb_data into rsX_data and sets rsX_data_valid at the edge.
  - This also applies to the entry being dispatched this cycle (dispatch-cycle capture), so no broadcast is missed.
  - rs1 and rs2 may both match in one cycle.
  - Wakeup applies after the shift, so data follows the entry.
  - Entries woken in cycle N become issuable in cycle N+1 (unless the bypass feature is enabled).
- Flush: at the next edge all valid bits are cleared. Flush overrides a simultaneous dispatch, issue and wakeup. issue_valid is not masked in the flush cycle; the handshake still completes toward the unit, and the unit is flushed separately.
- Latency: an entry dispatched with both operands valid in cycle N can issue in N+1 at the earliest.
- Count: queue_count = previous count + dispatch_fire - issue_fire. It never wraps; dispatch is gated by full, and issue is gated by count>0.

Optional Feature:
- Macro: INT_IQ_WAKEUP_BYPASS_EN.
- Defined:
  - The select logic treats an operand as valid if its stored rsX_data_valid=1, or if cdb_valid && rsX_tag==cdb_tag this cycle.
  - o_issue_data carries cdb_data in that operand slot, so an entry can issue in the same cycle as its wakeup broadcast.
- Undefined: selection uses stored valid bits only, giving one extra cycle of wakeup-to-issue latency.

Decomposition:
- Shared package (utils.sv): int_fifo_data and common_fifo_data typedefs (existing), the CDB tag width constant (6) and the data width constant (32).
- Natural sub-module: iq_oldest_ready_sel. It is a combinational priority encoder taking DEPTH ready bits and returning a found flag plus an index.

Test Plan:
- Reset, then dispatch ADDI (opcode 0x13, rs1_data=5, both valid), issue_ready=1 → issue_valid=1 next cycle, o_issue_data.rs1_data=5, queue_count returns to 0 after the handshake.
- Dispatch 4 entries with issue_ready=0 → queue_full=1, queue_count=4. A 5th dispatch sets dispatch_drop=1 and the count stays 4.
- Dispatch an entry with rs2_tag=0x12 not valid, then cdb_valid with cdb_tag=0x12, cdb_data=0xDEADBEEF:
  - Without the macro: issue one cycle after the broadcast, with rs2_data=0xDEADBEEF.
  - With INT_IQ_WAKEUP_BYPASS_EN: issue in the broadcast cycle.
- Entry0 waiting on tag 3, entry1 ready → entry1 issues first. Entry0 shifts and stays at index 0, and issues after CDB tag 3.
- Dispatch coincident with cdb_tag equal to the new entry's rs1_tag → captured; the entry issues with no further broadcast.
- Queue holding 3 entries, flush asserted together with int_dispatch_en → queue_count=0, queue_full=0 next cycle, and the dispatched entry is discarded.
